bmem_line_adapter: RTL and testbench
====================================

Name: bmem_line_adapter

Overview:
- Initiator side of the burst-memory interface.
- Converts single-cycle cache-line requests from the L2/shared cache into 4-beat bursts on the bmem bus, i.e. the burst_memory responder port.
- Sits between the cache arbiter and the top-level mp4 bmem_* pins.
- Owns burst sequencing, beat packing/unpacking and response generation.

Parameters:
- ADDR_WIDTH, 32, byte address width on both sides.
- LINE_WIDTH, 256, cache-line width in bits.
- BEAT_WIDTH, 64, bmem data width; BEATS = LINE_WIDTH/BEAT_WIDTH = 4.
- WDOG_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- line_address  in  ADDR_WIDTH  line byte address; low log2(LINE_WIDTH/8) bits ignored.
- line_read  in  1  line read request.
- line_write  in  1  line write request.
- line_wdata  in  LINE_WIDTH  line to write.
- line_rdata  out  LINE_WIDTH  assembled read line.
- line_resp  out  1  one-cycle completion pulse.
- bmem_address  out  ADDR_WIDTH  line-aligned burst address.
- bmem_read  out  1  burst read request.
- bmem_write  out  1  burst write beat valid.
- bmem_wdata  out  BEAT_WIDTH  write beat.
- bmem_rdata  in  BEAT_WIDTH  read beat.
- bmem_resp  in  1  read-beat valid / write-done.
- error  out  1  sticky watchdog error.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst=0 resets).
- Reset values: every output 0, line_rdata 0, state IDLE, beat counter 0.
- All outputs are registered.
- States: IDLE, RD_REQ, RD_BURST, WR_BURST, WR_WAIT, DONE.
- IDLE
  - Samples requests each edge.
  - line_read=1 → latch aligned address, go RD_REQ.
  - line_write=1 (read low) → latch address and line_wdata, go WR_BURST.
  - Both high → read wins; write is ignored until re-presented.
  - bmem_resp in IDLE is ignored.
- RD_REQ
  - bmem_read=1 and bmem_address stable until the first bmem_resp.
  - On the first resp: capture beat 0 into line_rdata[63:0], drop bmem_read, count=1, go RD_BURST.
- RD_BURST
  - Each bmem_resp=1 cycle captures beat[count] into bits [count*64+:64], then count++.
  - Responder guarantees 4 consecutive resp cycles; if resp drops mid-burst, the adapter holds its count and waits.
  - After beat 3: go DONE.
- WR_BURST
  - bmem_write=1 for exactly 4 consecutive cycles.
  - bmem_wdata = beat 0..3 (beat 0 = bits [63:0]).
  - bmem_address held stable.
  - Then go WR_WAIT with bmem_write=0.
- WR_WAIT: wait for bmem_resp=1, then go DONE.
- DONE
  - line_resp=1 for exactly one cycle; line_rdata valid in that cycle and held until the next read completes.
  - Then go IDLE.
  - Requester drops its request in the line_resp cycle; the earliest new acceptance is the IDLE cycle after DONE.
- Latency
  - Read: line_resp asserts 1 cycle after beat 3 is captured.
  - Write: bmem_write asserts 1 cycle after acceptance; line_resp asserts 1 cycle after write-done resp.
- Address: bmem_address = line_address with low 5 bits cleared, for the whole transaction.
- Requests arriving while busy are not queued; the requester holds them until line_resp.
- Reset mid-transaction
  - Immediate return to IDLE with all outputs 0; the burst is abandoned.
  - The responder shares the same reset.

Optional Feature:
- Macro: BMEM_LINE_ADAPTER_WDOG_EN.
- Defined
  - Counter runs in RD_REQ, RD_BURST and WR_WAIT; it clears on each bmem_resp and on every state change.
  - Reaching WDOG_CYCLES sets error=1 (sticky until reset) and forces DONE.
  - That DONE pulses line_resp, so the pipeline does not hang; line_rdata is undefined in that case.
- Undefined: no counter logic; error tied 0; adapter waits indefinitely.

Test Plan:
- Read 0x0000_1234; responder returns beats A0,A1,A2,A3 starting 3 cycles after bmem_read → bmem_address=0x0000_1220; line_rdata={A3,A2,A1,A0}; line_resp single pulse 1 cycle after A3.
- Write 0x8000_0040 with line {D3,D2,D1,D0}; responder resp 2 cycles after last beat → bmem_write high exactly 4 cycles carrying D0..D3; line_resp pulse 1 cycle after resp.
- line_read and line_write both high in IDLE → only bmem_read asserts; bmem_write stays 0 for the whole transaction.
- Read with resp gap after beat 1 (resp 1,1,0,1,1) → beats land in correct slots; line_resp after fourth valid beat.
- rst=0 during WR_BURST beat 2 → all outputs 0 immediately; after release, a new read completes correctly.
- With BMEM_LINE_ADAPTER_WDOG_EN and WDOG_CYCLES=16, responder never responds → error=1 and line_resp pulse at cycle 16; without the macro, error stays 0 and no line_resp is ever seen.

Source files
------------

// File: rtl/bmem_line_adapter.sv
// bmem_line_adapter: initiator side of the burst-memory interface.
// Turns single-cycle cache-line read/write requests into 4-beat bursts on the
// bmem bus, packs/unpacks beats and returns a one-cycle line_resp pulse.
// Optional watchdog: define BMEM_LINE_ADAPTER_WDOG_EN to enable a stall
// counter that sets a sticky error and forces completion after WDOG_CYCLES.
module bmem_line_adapter #(
   parameter int ADDR_WIDTH  = 32,
   parameter int LINE_WIDTH  = 256,
   parameter int BEAT_WIDTH  = 64,
   parameter int WDOG_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] line_address,
   input  logic                  line_read,
   input  logic                  line_write,
   input  logic [LINE_WIDTH-1:0] line_wdata,
   output logic [LINE_WIDTH-1:0] line_rdata,
   output logic                  line_resp,
   output logic [ADDR_WIDTH-1:0] bmem_address,
   output logic                  bmem_read,
   output logic                  bmem_write,
   output logic [BEAT_WIDTH-1:0] bmem_wdata,
   input  logic [BEAT_WIDTH-1:0] bmem_rdata,
   input  logic                  bmem_resp,
   output logic                  error
);

   localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int OFFS  = $clog2(LINE_WIDTH / 8);
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_REQ   = 3'd1,
      RD_BURST = 3'd2,
      WR_BURST = 3'd3,
      WR_WAIT  = 3'd4,
      DONE     = 3'd5
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic                    rd_q, rd_d;
   logic                    wr_q, wr_d;
   logic [BEAT_WIDTH-1:0]   wdata_q, wdata_d;
   logic [LINE_WIDTH-1:0]   wbuf_q, wbuf_d;
   logic [LINE_WIDTH-1:0]   rdbuf_q, rdbuf_d;
   logic [LINE_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    resp_q, resp_d;

   logic [ADDR_WIDTH-1:0]   aligned_addr;
   logic [CNT_W-1:0]        cnt_inc;
   logic [LINE_WIDTH-1:0]   rd_merged;
   logic [BEAT_WIDTH-1:0]   wbeat [BEATS];
   logic                    timeout;
   logic                    unused_addr;

   // Offset bits inside the line are deliberately dropped.
   assign unused_addr = ^line_address[OFFS-1:0];
   assign cnt_inc     = count_q + CNT_W'(1);

   // Line-aligned burst address: clear the byte-in-line offset.
   always_comb begin
      aligned_addr = line_address;
      aligned_addr[OFFS-1:0] = '0;
   end

   // Per-beat views: write beats sliced out of the latched line, and the read
   // line with the incoming beat dropped into the slot addressed by count_q.
   for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
      localparam logic [CNT_W-1:0] SLOT = CNT_W'(gi);
      assign wbeat[gi] = wbuf_q[gi*BEAT_WIDTH +: BEAT_WIDTH];
      assign rd_merged[gi*BEAT_WIDTH +: BEAT_WIDTH] =
         (count_q == SLOT) ? bmem_rdata : rdbuf_q[gi*BEAT_WIDTH +: BEAT_WIDTH];
   end

   // Next-state and registered-output logic of the burst sequencer.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      addr_d  = addr_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      wbuf_d  = wbuf_q;
      rdbuf_d = rdbuf_q;
      rdata_d = rdata_q;
      resp_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Read has priority; a simultaneous write is simply not taken.
            if (line_read) begin
               addr_d  = aligned_addr;
               rd_d    = 1'b1;
               count_d = '0;
               state_d = RD_REQ;
            end else if (line_write) begin
               addr_d  = aligned_addr;
               wbuf_d  = line_wdata;
               wr_d    = 1'b1;
               wdata_d = line_wdata[BEAT_WIDTH-1:0];
               count_d = '0;
               state_d = WR_BURST;
            end
         end
         RD_REQ: begin
            if (bmem_resp) begin
               rdbuf_d = rd_merged;
               rd_d    = 1'b0;
               count_d = cnt_inc;
               state_d = RD_BURST;
            end
         end
         RD_BURST: begin
            // A gap in bmem_resp just holds the count.
            if (bmem_resp) begin
               rdbuf_d = rd_merged;
               count_d = cnt_inc;
               if (count_q == LAST_BEAT) begin
                  rdata_d = rd_merged;
                  resp_d  = 1'b1;
                  count_d = '0;
                  state_d = DONE;
               end
            end
         end
         WR_BURST: begin
            count_d = cnt_inc;
            wdata_d = wbeat[cnt_inc];
            if (count_q == LAST_BEAT) begin
               wr_d    = 1'b0;
               wdata_d = '0;
               count_d = '0;
               state_d = WR_WAIT;
            end
         end
         WR_WAIT: begin
            if (bmem_resp) begin
               resp_d  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // A stalled responder is abandoned and the requester released.
      if (timeout) begin
         rd_d    = 1'b0;
         resp_d  = 1'b1;
         count_d = '0;
         state_d = DONE;
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         count_q <= '0;
         addr_q  <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         wbuf_q  <= '0;
         rdbuf_q <= '0;
         rdata_q <= '0;
         resp_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         addr_q  <= addr_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         wdata_q <= wdata_d;
         wbuf_q  <= wbuf_d;
         rdbuf_q <= rdbuf_d;
         rdata_q <= rdata_d;
         resp_q  <= resp_d;
      end
   end

`ifdef BMEM_LINE_ADAPTER_WDOG_EN
   localparam int WD_W = $clog2(WDOG_CYCLES + 1);

   logic [WD_W-1:0] wdog_q, wdog_d;
   logic            error_q, error_d;
   logic            wd_busy;

   // Stall detection: expire on the last quiet cycle of the window.
   always_comb begin
      wd_busy = (state_q == RD_REQ) || (state_q == RD_BURST) || (state_q == WR_WAIT);
      timeout = wd_busy && !bmem_resp && (wdog_q == WD_W'(WDOG_CYCLES - 1));
   end

   // Counter restarts on any responder activity or state change.
   always_comb begin
      wdog_d  = wdog_q + WD_W'(1);
      if (!wd_busy || bmem_resp || (state_d != state_q)) begin
         wdog_d = '0;
      end
      error_d = error_q | timeout;
   end

   // Watchdog count and sticky error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wdog_q  <= '0;
         error_q <= 1'b0;
      end else begin
         wdog_q  <= wdog_d;
         error_q <= error_d;
      end
   end

   assign error = error_q;
`else
   logic unused_wdog;
   assign unused_wdog = ^32'(WDOG_CYCLES);
   assign timeout     = 1'b0;
   assign error       = 1'b0;
`endif

   assign line_rdata   = rdata_q;
   assign line_resp    = resp_q;
   assign bmem_address = addr_q;
   assign bmem_read    = rd_q;
   assign bmem_write   = wr_q;
   assign bmem_wdata   = wdata_q;

endmodule

// File: tb/tb_bmem_line_adapter.sv
// Directed testbench for bmem_line_adapter: reads, writes, read/write
// collision, responder gaps, mid-burst reset and the stall behaviour.
module tb_bmem_line_adapter;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [31:0]  line_address = '0;
   logic         line_read = 1'b0;
   logic         line_write = 1'b0;
   logic [255:0] line_wdata = '0;
   logic [255:0] line_rdata;
   logic         line_resp;
   logic [31:0]  bmem_address;
   logic         bmem_read;
   logic         bmem_write;
   logic [63:0]  bmem_wdata;
   logic [63:0]  bmem_rdata = '0;
   logic         bmem_resp = 1'b0;
   logic         error;

   int n_pass  = 0;
   int n_total = 0;

   bmem_line_adapter #(
      .ADDR_WIDTH (32),
      .LINE_WIDTH (256),
      .BEAT_WIDTH (64),
      .WDOG_CYCLES(16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .line_address(line_address),
      .line_read   (line_read),
      .line_write  (line_write),
      .line_wdata  (line_wdata),
      .line_rdata  (line_rdata),
      .line_resp   (line_resp),
      .bmem_address(bmem_address),
      .bmem_read   (bmem_read),
      .bmem_write  (bmem_write),
      .bmem_wdata  (bmem_wdata),
      .bmem_rdata  (bmem_rdata),
      .bmem_resp   (bmem_resp),
      .error       (error)
   );

   always #5 clk = ~clk;

   // Stimulus only: issue a read (optionally with write also high) and play a
   // responder. plan[k] = drive a beat at negedge k after acceptance.
   // Returns what was observed; the calling scenario does the checking.
   task automatic drive_read(input logic [31:0] addr, input logic also_write,
                             input logic [15:0] plan,
                             input logic [63:0] b0, input logic [63:0] b1,
                             input logic [63:0] b2, input logic [63:0] b3,
                             output int resp_cnt, output int resp_cyc,
                             output logic [255:0] rdata_snap,
                             output logic [31:0] addr_seen,
                             output int rd_cycles, output int wr_cycles);
      logic [63:0] b [4];
      int bi;
      b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
      bi = 0; resp_cnt = 0; resp_cyc = 0; rdata_snap = '0; addr_seen = '0;
      rd_cycles = 0; wr_cycles = 0;
      line_address = addr;
      line_read    = 1'b1;
      line_write   = also_write;
      line_wdata   = {4{64'hFFFF_0000_FFFF_0000}};
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (k == 1) addr_seen = bmem_address;
         if (bmem_read)  rd_cycles++;
         if (bmem_write) wr_cycles++;
         if (line_resp) begin
            resp_cnt++;
            resp_cyc   = k;
            rdata_snap = line_rdata;
            line_read  = 1'b0;
            line_write = 1'b0;
         end
         if (plan[k] && bi < 4) begin
            bmem_resp  = 1'b1;
            bmem_rdata = b[bi];
            bi++;
         end else begin
            bmem_resp  = 1'b0;
            bmem_rdata = '0;
         end
      end
      line_read  = 1'b0;
      line_write = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_total++;
      if ({bmem_read, bmem_write, line_resp, error} !== 4'b0)
         $display("FAIL reset_ctrl: {rd,wr,resp,err}=%b expected 0000",
                  {bmem_read, bmem_write, line_resp, error});
      else n_pass++;
      n_total++;
      if ({bmem_address, bmem_wdata} !== 96'h0)
         $display("FAIL reset_bus: addr=%h wdata=%h expected 0", bmem_address, bmem_wdata);
      else n_pass++;
      n_total++;
      if (line_rdata !== 256'h0)
         $display("FAIL reset_rdata: %h expected 0", line_rdata);
      else n_pass++;
      rst = 1'b1;
      @(negedge clk);
      $display("test_reset done");
   endtask

   task automatic test_read();
      int rc, cyc, rdc, wrc;
      logic [255:0] snap;
      logic [31:0] a;
      drive_read(32'h0000_1234, 1'b0, 16'b0000_0000_0111_1000,
                 64'h0123_4567_89AB_CDEF, 64'h1111_2222_3333_4444,
                 64'hDEAD_BEEF_CAFE_F00D, 64'hA5A5_5A5A_0F0F_F0F0,
                 rc, cyc, snap, a, rdc, wrc);
      n_total++;
      if (a !== 32'h0000_1220) $display("FAIL read_addr: %h expected 00001220", a);
      else n_pass++;
      n_total++;
      if (rdc !== 3) $display("FAIL read_req_cycles: %0d expected 3", rdc);
      else n_pass++;
      n_total++;
      if (rc !== 1 || cyc !== 7)
         $display("FAIL read_resp: count=%0d cycle=%0d expected 1 at 7", rc, cyc);
      else n_pass++;
      n_total++;
      if (snap !== {64'hA5A5_5A5A_0F0F_F0F0, 64'hDEAD_BEEF_CAFE_F00D,
                    64'h1111_2222_3333_4444, 64'h0123_4567_89AB_CDEF})
         $display("FAIL read_data: %h", snap);
      else n_pass++;
      n_total++;
      if (line_rdata !== snap) $display("FAIL read_hold: %h expected %h", line_rdata, snap);
      else n_pass++;
      $display("test_read addr=%h resp_cycle=%0d", a, cyc);
   endtask

   task automatic test_write();
      logic [63:0] d [4];
      int wr_cnt, wr_first, data_err, rc, cyc;
      logic [31:0] a;
      d[0] = 64'hD0D0_0000_0000_0001; d[1] = 64'hD1D1_0000_0000_0002;
      d[2] = 64'hD2D2_0000_0000_0003; d[3] = 64'hD3D3_0000_0000_0004;
      wr_cnt = 0; wr_first = 0; data_err = 0; rc = 0; cyc = 0; a = '0;
      line_address = 32'h8000_005C;
      line_wdata   = {d[3], d[2], d[1], d[0]};
      line_write   = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (k == 1) a = bmem_address;
         if (bmem_write) begin
            if (wr_first == 0) wr_first = k;
            if (wr_cnt < 4 && bmem_wdata !== d[wr_cnt]) data_err++;
            wr_cnt++;
         end
         if (line_resp) begin
            rc++;
            cyc = k;
            line_write = 1'b0;
         end
         bmem_resp = (k == 6);
      end
      bmem_resp = 1'b0;
      n_total++;
      if (a !== 32'h8000_0040) $display("FAIL write_addr: %h expected 80000040", a);
      else n_pass++;
      n_total++;
      if (wr_cnt !== 4 || wr_first !== 1)
         $display("FAIL write_beats: count=%0d first=%0d expected 4 at 1", wr_cnt, wr_first);
      else n_pass++;
      n_total++;
      if (data_err !== 0) $display("FAIL write_data: %0d bad beats expected 0", data_err);
      else n_pass++;
      n_total++;
      if (rc !== 1 || cyc !== 7)
         $display("FAIL write_resp: count=%0d cycle=%0d expected 1 at 7", rc, cyc);
      else n_pass++;
      $display("test_write addr=%h beats=%0d resp_cycle=%0d", a, wr_cnt, cyc);
   endtask

   task automatic test_read_write_collision();
      int rc, cyc, rdc, wrc;
      logic [255:0] snap;
      logic [31:0] a;
      drive_read(32'h0000_0FFF, 1'b1, 16'b0000_0000_0111_1000,
                 64'h1, 64'h2, 64'h3, 64'h4, rc, cyc, snap, a, rdc, wrc);
      n_total++;
      if (rdc !== 3 || wrc !== 0)
         $display("FAIL collide_sel: rd_cycles=%0d wr_cycles=%0d expected 3 and 0", rdc, wrc);
      else n_pass++;
      n_total++;
      if (a !== 32'h0000_0FE0 || rc !== 1 || snap !== {64'h4, 64'h3, 64'h2, 64'h1})
         $display("FAIL collide_read: addr=%h resp=%0d data=%h", a, rc, snap);
      else n_pass++;
      $display("test_read_write_collision rd=%0d wr=%0d", rdc, wrc);
   endtask

   task automatic test_read_gap();
      int rc, cyc, rdc, wrc;
      logic [255:0] snap;
      logic [31:0] a;
      // Beats at negedges 3,4,(gap 5),6,7.
      drive_read(32'h0000_2040, 1'b0, 16'b0000_0000_1101_1000,
                 64'hB0, 64'hB1, 64'hB2, 64'hB3, rc, cyc, snap, a, rdc, wrc);
      n_total++;
      if (rc !== 1 || cyc !== 8)
         $display("FAIL gap_resp: count=%0d cycle=%0d expected 1 at 8", rc, cyc);
      else n_pass++;
      n_total++;
      if (snap !== {64'hB3, 64'hB2, 64'hB1, 64'hB0}) $display("FAIL gap_data: %h", snap);
      else n_pass++;
      $display("test_read_gap resp_cycle=%0d", cyc);
   endtask

   task automatic test_reset_mid_write();
      int rc, cyc, rdc, wrc;
      logic [255:0] snap;
      logic [31:0] a;
      line_address = 32'h0000_3000;
      line_wdata   = {64'hE3, 64'hE2, 64'hE1, 64'hE0};
      line_write   = 1'b1;
      repeat (3) @(negedge clk);
      n_total++;
      if (bmem_write !== 1'b1 || bmem_wdata !== 64'hE2)
         $display("FAIL rstmid_beat2: wr=%b wdata=%h expected 1 and e2", bmem_write, bmem_wdata);
      else n_pass++;
      #2 rst = 1'b0;
      #1;
      n_total++;
      if ({bmem_read, bmem_write, line_resp, error} !== 4'b0 ||
          bmem_address !== 32'h0 || bmem_wdata !== 64'h0 || line_rdata !== 256'h0)
         $display("FAIL rstmid_outputs: rd=%b wr=%b resp=%b addr=%h wdata=%h rdata=%h expected all 0",
                  bmem_read, bmem_write, line_resp, bmem_address, bmem_wdata, line_rdata);
      else n_pass++;
      line_write = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      drive_read(32'h0000_3010, 1'b0, 16'b0000_0000_0111_1000,
                 64'hC0, 64'hC1, 64'hC2, 64'hC3, rc, cyc, snap, a, rdc, wrc);
      n_total++;
      if (rc !== 1 || cyc !== 7 || snap !== {64'hC3, 64'hC2, 64'hC1, 64'hC0} || wrc !== 0)
         $display("FAIL rstmid_read: resp=%0d cycle=%0d wr=%0d data=%h", rc, cyc, wrc, snap);
      else n_pass++;
      $display("test_reset_mid_write recovered resp_cycle=%0d", cyc);
   endtask

   task automatic test_stall();
      int rc, cyc, err_seen;
      rc = 0; cyc = 0; err_seen = 0;
      line_address = 32'h0000_0040;
      line_read    = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (error) err_seen = 1;
         if (line_resp) begin
            rc++;
            cyc = k;
            line_read = 1'b0;
         end
      end
      line_read = 1'b0;
`ifdef BMEM_LINE_ADAPTER_WDOG_EN
      n_total++;
      if (rc !== 1 || cyc < 16 || cyc > 17)
         $display("FAIL stall_resp: count=%0d cycle=%0d expected 1 at 16..17", rc, cyc);
      else n_pass++;
      n_total++;
      if (error !== 1'b1) $display("FAIL stall_error: %b expected 1", error);
      else n_pass++;
`else
      n_total++;
      if (rc !== 0) $display("FAIL stall_resp: count=%0d expected 0", rc);
      else n_pass++;
      n_total++;
      if (err_seen !== 0 || bmem_read !== 1'b1)
         $display("FAIL stall_wait: err_seen=%0d bmem_read=%b expected 0 and 1", err_seen, bmem_read);
      else n_pass++;
`endif
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      n_total++;
      if (error !== 1'b0 || bmem_read !== 1'b0)
         $display("FAIL stall_clear: err=%b rd=%b expected 0 0", error, bmem_read);
      else n_pass++;
      $display("test_stall resp_count=%0d resp_cycle=%0d", rc, cyc);
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_read_write_collision();
      test_read_gap();
      test_reset_mid_write();
      test_stall();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
